execute_stage: RTL and testbench

//  Execute (E) stage of the pipelined ARM core; consumes the outputs of the Decode->Execute pipeline register.

---
 rtl/core_pkg.sv | 47 ++++
 rtl/condcheck.sv | 40 ++++
 rtl/execute_stage.sv | 153 +++++++++++++++
 tb/tb_execute_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: ALU opcodes, ARM condition codes, forwarding selects.
// Imported by every pipeline stage of the core.
package core_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      ORR = 4'd3,
      EOR = 4'd4,
      RSB = 4'd5,
      MOV = 4'd6,
      BIC = 4'd7,
      MVN = 4'd8
   } alu_op_t;

   typedef enum logic [3:0] {
      EQ = 4'd0,
      NE = 4'd1,
      CS = 4'd2,
      CC = 4'd3,
      MI = 4'd4,
      PL = 4'd5,
      VS = 4'd6,
      VC = 4'd7,
      HI = 4'd8,
      LS = 4'd9,
      GE = 4'd10,
      LT = 4'd11,
      GT = 4'd12,
      LE = 4'd13,
      AL = 4'd14,
      NV = 4'd15
   } cond_t;

   typedef enum logic [1:0] {
      REG = 2'd0,
      WB  = 2'd1,
      MEM = 2'd2
   } fwd_sel_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// ARM condition evaluation: cond field + current NZCV -> condex.
// Ports: cond[3:0], flags[3:0] {N,Z,C,V}; out condex.
module condcheck
   import core_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      condex = 1'b0;
      case (cond)
         EQ:      condex = z;
         NE:      condex = !z;
         CS:      condex = c;
         CC:      condex = !c;
         MI:      condex = n;
         PL:      condex = !n;
         VS:      condex = v;
         VC:      condex = !v;
         HI:      condex = c && !z;
         LS:      condex = !c || z;
         GE:      condex = (n == v);
         LT:      condex = (n != v);
         GT:      condex = !z && (n == v);
         LE:      condex = z || (n != v);
         AL:      condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, NZCV register, cond gating, E/M reg.
// Ports: D/E controls+operands in, ResultW fwd in; ALUResultE/BranchTakenE/FlagsE, M bundle out.
module execute_stage
   import core_pkg::*;
#(
   parameter int         DATA_W    = 32,
   parameter logic [3:0] FLAGS_RST = 4'b0000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrcE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic              ALUSrcE,
   input  logic              BranchE,
   input  logic [1:0]        FlagWriteE,
   input  logic [3:0]        ALUControlE,
   input  logic [3:0]        CondE,
   input  logic [3:0]        RdE,
   input  logic [3:0]        byteEnableE,
   input  logic [DATA_W-1:0] Rd1E,
   input  logic [DATA_W-1:0] Rd2E,
   input  logic [DATA_W-1:0] ExtE,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [DATA_W-1:0] ResultW,
   output logic [DATA_W-1:0] ALUResultE,
   output logic              BranchTakenE,
   output logic [3:0]        FlagsE,
   output logic              PCSrcM,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              MemtoRegM,
   output logic [DATA_W-1:0] ALUResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [3:0]        RdM,
   output logic [3:0]        byteEnableM
);

   logic [DATA_W-1:0] srca, srcb, wdata;
   logic [DATA_W-1:0] ax, bx;
   logic [DATA_W:0]   sum;
   logic              cin, arith, cv_upd;
   logic              c_res, v_res;
   logic              condex;

   always_comb begin
      case (ForwardAE)
         MEM:     srca = ALUResultM;
         WB:      srca = ResultW;
         default: srca = Rd1E;
      endcase
      case (ForwardBE)
         MEM:     wdata = ALUResultM;
         WB:      wdata = ResultW;
         default: wdata = Rd2E;
      endcase
   end

   assign srcb = ALUSrcE ? ExtE : wdata;

   // One shared adder: SUB is a+~b+1, RSB is b+~a+1.
   always_comb begin
      ax         = srca;
      bx         = srcb;
      cin        = 1'b0;
      arith      = 1'b0;
      cv_upd     = 1'b0;
      ALUResultE = '0;
      case (ALUControlE)
         ADD: begin
            arith = 1'b1;
         end
         SUB: begin
            bx    = ~srcb;
            cin   = 1'b1;
            arith = 1'b1;
         end
         RSB: begin
            ax    = srcb;
            bx    = ~srca;
            cin   = 1'b1;
            arith = 1'b1;
         end
         AND:     ALUResultE = srca & srcb;
         ORR:     ALUResultE = srca | srcb;
         EOR:     ALUResultE = srca ^ srcb;
         BIC:     ALUResultE = srca & ~srcb;
         MOV:     ALUResultE = srcb;
         MVN:     ALUResultE = ~srcb;
         // Undefined: zero result, C/V forced to zero.
         default: cv_upd = 1'b1;
      endcase
      sum = {1'b0, ax} + {1'b0, bx}
          + {{DATA_W{1'b0}}, cin};
      if (arith) begin
         ALUResultE = sum[DATA_W-1:0];
         cv_upd     = 1'b1;
      end
   end

   assign c_res = arith & sum[DATA_W];
   assign v_res = arith
                & (ax[DATA_W-1] == bx[DATA_W-1])
                & (sum[DATA_W-1] != ax[DATA_W-1]);

   condcheck u_cond (
      .cond   (CondE),
      .flags  (FlagsE),
      .condex (condex)
   );

   assign BranchTakenE = BranchE & condex;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         FlagsE <= FLAGS_RST;
      end else if (condex) begin
         if (FlagWriteE[1]) begin
            FlagsE[FLAG_N] <= ALUResultE[DATA_W-1];
            FlagsE[FLAG_Z] <= (ALUResultE == '0);
         end
         if (FlagWriteE[0] && cv_upd) begin
            FlagsE[FLAG_C] <= c_res;
            FlagsE[FLAG_V] <= v_res;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PCSrcM      <= 1'b0;
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         MemtoRegM   <= 1'b0;
         ALUResultM  <= '0;
         WriteDataM  <= '0;
         RdM         <= '0;
         byteEnableM <= '0;
      end else begin
         PCSrcM      <= PCSrcE & condex;
         RegWriteM   <= RegWriteE & condex;
         MemWriteM   <= MemWriteE & condex;
         MemtoRegM   <= MemtoRegE;
         ALUResultM  <= ALUResultE;
         WriteDataM  <= wdata;
         RdM         <= RdE;
         byteEnableM <= byteEnableE;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Randomised self-checking bench for execute_stage against an
// arithmetic reference model of forwarding, ALU, flags and gating.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
   logic        ALUSrcE, BranchE;
   logic [1:0]  FlagWriteE;
   logic [3:0]  ALUControlE, CondE, RdE, byteEnableE;
   logic [31:0] Rd1E, Rd2E, ExtE, ResultW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultE, ALUResultM, WriteDataM;
   logic        BranchTakenE;
   logic [3:0]  FlagsE, RdM, byteEnableM;
   logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  m_flags;
   logic [31:0] m_alum, m_wdm;
   logic [3:0]  m_rdm, m_bem;
   logic        m_pcs, m_rw, m_mw, m_m2r;

   execute_stage dut (
      .clk(clk), .reset(reset),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .BranchE(BranchE),
      .FlagWriteE(FlagWriteE), .ALUControlE(ALUControlE),
      .CondE(CondE), .RdE(RdE), .byteEnableE(byteEnableE),
      .Rd1E(Rd1E), .Rd2E(Rd2E), .ExtE(ExtE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW),
      .ALUResultE(ALUResultE), .BranchTakenE(BranchTakenE),
      .FlagsE(FlagsE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .byteEnableM(byteEnableM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel,
                                       input logic [31:0] r);
      if (sel == 2'b10) return m_alum;
      if (sel == 2'b01) return ResultW;
      return r;
   endfunction

   function automatic logic cond_ok(input logic [3:0] cd,
                                    input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cd)
         0:  return z;
         1:  return !z;
         2:  return c;
         3:  return !c;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return c && !z;
         9:  return !c || z;
         10: return n == v;
         11: return n != v;
         12: return !z && n == v;
         13: return z || n != v;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Plain integer arithmetic: carry = unsigned no-borrow/overflow,
   // V = signed result out of 32-bit range.
   function automatic void ref_alu(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] r,
                                   output logic c,
                                   output logic v,
                                   output logic cvw);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      c = 1'b0; v = 1'b0; cvw = 1'b0; r = '0;
      case (op)
         0: begin
            r = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
            v = ovf(sa + sb); cvw = 1'b1;
         end
         1: begin
            r = a - b; c = (a >= b); v = ovf(sa - sb); cvw = 1'b1;
         end
         5: begin
            r = b - a; c = (b >= a); v = ovf(sb - sa); cvw = 1'b1;
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         6: r = b;
         7: r = a & ~b;
         8: r = ~b;
         default: begin r = '0; cvw = 1'b1; end
      endcase
   endfunction

   task automatic model_reset();
      m_flags = 4'b0000;
      m_alum = '0; m_wdm = '0; m_rdm = '0; m_bem = '0;
      m_pcs = 0; m_rw = 0; m_mw = 0; m_m2r = 0;
   endtask

   task automatic check_regs(input string t);
      chk({t, "_flags"}, {28'd0, FlagsE}, {28'd0, m_flags});
      chk({t, "_alum"}, ALUResultM, m_alum);
      chk({t, "_wdm"}, WriteDataM, m_wdm);
      chk({t, "_rdbe"}, {24'd0, RdM, byteEnableM},
                        {24'd0, m_rdm, m_bem});
      chk({t, "_ctl"},
          {28'd0, PCSrcM, RegWriteM, MemWriteM, MemtoRegM},
          {28'd0, m_pcs, m_rw, m_mw, m_m2r});
   endtask

   task automatic set_idle();
      {PCSrcE, RegWriteE, MemtoRegE, MemWriteE} = '0;
      {ALUSrcE, BranchE} = '0;
      FlagWriteE = 0; ALUControlE = 0; CondE = 4'd14;
      RdE = 0; byteEnableE = 0;
      Rd1E = 0; Rd2E = 0; ExtE = 0; ResultW = 0;
      ForwardAE = 0; ForwardBE = 0;
   endtask

   // Inputs are already applied; check combinational outputs,
   // clock once, advance the model, check registered state.
   task automatic cycle(input string t);
      logic [31:0] a, wd, b, r;
      logic c, v, cvw, ce;
      #3;
      a  = fwd(ForwardAE, Rd1E);
      wd = fwd(ForwardBE, Rd2E);
      b  = ALUSrcE ? ExtE : wd;
      ref_alu(ALUControlE, a, b, r, c, v, cvw);
      ce = cond_ok(CondE, m_flags);
      chk({t, "_aluE"}, ALUResultE, r);
      chk({t, "_brE"}, {31'd0, BranchTakenE}, {31'd0, BranchE & ce});
      @(posedge clk);
      if (ce) begin
         if (FlagWriteE[1]) m_flags[3:2] = {r[31], r == 0};
         if (FlagWriteE[0] && cvw) m_flags[1:0] = {c, v};
      end
      m_pcs = PCSrcE & ce;
      m_rw  = RegWriteE & ce;
      m_mw  = MemWriteE & ce;
      m_m2r = MemtoRegE;
      m_alum = r; m_wdm = wd; m_rdm = RdE; m_bem = byteEnableE;
      #1;
      check_regs(t);
   endtask

   task automatic do_reset(input string t);
      reset = 1'b1;
      #2;
      model_reset();
      check_regs(t);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      RdE = 4'hF; byteEnableE = 4'hF; Rd1E = 32'hFFFF_FFFF;
      @(negedge clk);
      do_reset("t1");
      set_idle();

      // ADD 0x7FFFFFFF + 1 -> N,V
      Rd1E = 32'h7FFF_FFFF; ALUSrcE = 1; ExtE = 1;
      ALUControlE = 4'd0; FlagWriteE = 2'b11;
      cycle("t2");
      chk("t2_res", ALUResultM, 32'h8000_0000);
      chk("t2_nzcv", {28'd0, FlagsE}, 32'h9);

      // SUB 5-5 -> Z,C; then EQ / NE gating
      set_idle();
      Rd1E = 5; ALUSrcE = 1; ExtE = 5;
      ALUControlE = 4'd1; FlagWriteE = 2'b11;
      cycle("t3s");
      chk("t3_nzcv", {28'd0, FlagsE}, 32'h6);
      set_idle();
      ALUControlE = 4'd6; RegWriteE = 1; CondE = 4'd0;
      cycle("t3eq");
      chk("t3_eq_rw", {31'd0, RegWriteM}, 32'd1);
      CondE = 4'd1;
      cycle("t3ne");
      chk("t3_ne_rw", {31'd0, RegWriteM}, 32'd0);

      // failed NE: no store, no flag change
      set_idle();
      CondE = 4'd1; MemWriteE = 1; FlagWriteE = 2'b11;
      Rd1E = 32'hFFFF_FFFF; ALUSrcE = 1; ExtE = 1;
      cycle("t4");
      chk("t4_mw", {31'd0, MemWriteM}, 32'd0);
      chk("t4_nzcv", {28'd0, FlagsE}, 32'h6);

      // forwarding from M and W
      set_idle();
      ALUControlE = 4'd6; ALUSrcE = 1; ExtE = 32'h10;
      cycle("t5a");
      set_idle();
      ForwardAE = 2'b10; Rd1E = 32'h99; ALUSrcE = 1; ExtE = 1;
      ForwardBE = 2'b01; Rd2E = 32'h55; ResultW = 32'hABCD_1234;
      cycle("t5b");
      chk("t5_alum", ALUResultM, 32'h11);
      chk("t5_wdm", WriteDataM, 32'hABCD_1234);

      // GE branch with N=V=1, then N=1,V=0
      set_idle();
      Rd1E = 32'h7FFF_FFFF; ALUSrcE = 1; ExtE = 1;
      FlagWriteE = 2'b11;
      cycle("t6a");
      set_idle();
      BranchE = 1; PCSrcE = 1; CondE = 4'd10;
      cycle("t6b");
      chk("t6_pcs1", {31'd0, PCSrcM}, 32'd1);
      set_idle();
      Rd1E = 32'h8000_0000; ALUSrcE = 1; ExtE = 0;
      ALUControlE = 4'd1; FlagWriteE = 2'b11;
      cycle("t6c");
      chk("t6_nzcv", {28'd0, FlagsE}, 32'hA);
      set_idle();
      BranchE = 1; PCSrcE = 1; CondE = 4'd10;
      #3;
      chk("t6_br0", {31'd0, BranchTakenE}, 32'd0);
      cycle("t6d");
      chk("t6_pcs0", {31'd0, PCSrcM}, 32'd0);

      for (int i = 0; i < 400; i++) begin
         {PCSrcE, RegWriteE, MemtoRegE, MemWriteE} = 4'($urandom);
         ALUSrcE = 1'($urandom);
         BranchE = 1'($urandom);
         ALUControlE = ($urandom_range(0, 9) == 0)
                       ? 4'($urandom) : 4'($urandom_range(0, 8));
         FlagWriteE = 2'($urandom);
         if (ALUControlE > 4'd8) FlagWriteE[0] = 1'b0;
         CondE = 4'($urandom);
         RdE = 4'($urandom);
         byteEnableE = 4'($urandom);
         Rd1E = ($urandom_range(0, 3) == 0)
                ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2))
                : $urandom;
         Rd2E = $urandom;
         ExtE = ($urandom_range(0, 3) == 0) ? Rd1E : $urandom;
         ResultW = $urandom;
         ForwardAE = 2'($urandom);
         ForwardBE = 2'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            #2;
            do_reset("rrst");
         end else begin
            cycle("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
